// File: rtl/clock_ratio_monitor.sv
`default_nettype none
// ============================================================================
// clock_ratio_monitor : measures sig_in half-periods in clk_in cycles and
//                       reports lock / loss against the expected FACTOR.
// Revision            : 1.0
// ============================================================================
module clock_ratio_monitor #(
  parameter logic [7:0]  FACTOR     = 8'd5,
  parameter logic [7:0]  TOLERANCE  = 8'd0,
  parameter int unsigned LOCK_COUNT = 4,
  parameter logic [7:0]  TIMEOUT    = 8'd32
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       sig_in,
  output logic       locked,
  output logic       lost,
  output logic       period_valid,
  output logic [7:0] half_period,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

  logic              s1_q, s2_q, s3_q;
  logic        [7:0] cnt_q, cnt_d;
  state_t            state_q, state_d;
  logic        [3:0] match_cnt_q, match_cnt_d;
  logic              locked_q, lost_q;
  logic              pv_q, pv_d;
  logic        [7:0] hp_q, hp_d;
  logic        [7:0] err_q, err_d;

  logic              sig_edge;
  logic signed [8:0] diff;
  logic        [8:0] abs_diff;
  logic              match;

  assign sig_edge = s2_q ^ s3_q;

  // 9-bit signed difference so cnt far from FACTOR cannot wrap into a match
  assign diff     = $signed({1'b0, cnt_q}) - $signed({1'b0, FACTOR});
  assign abs_diff = diff[8] ? $unsigned(-diff) : $unsigned(diff);
  assign match    = (abs_diff <= {1'b0, TOLERANCE});

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    pv_d        = 1'b0;
    hp_d        = hp_q;
    err_d       = err_q;
    cnt_d       = sig_edge ? 8'd1 : ((cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1);

    case (state_q)
      IDLE: begin
        if (sig_edge) begin
          state_d     = ACQUIRE;
          match_cnt_d = '0;
        end
      end
      ACQUIRE: begin
        if (sig_edge) begin
          pv_d = 1'b1;
          hp_d = cnt_q;
          if (match) begin
            match_cnt_d = match_cnt_q + 4'd1;
            if ((match_cnt_q + 4'd1) == LOCK_TARGET) state_d = LOCKED;
          end else begin
            match_cnt_d = '0;
          end
        end else if (cnt_q == TIMEOUT) begin
          state_d     = LOST;
          match_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (sig_edge) begin
          pv_d = 1'b1;
          hp_d = cnt_q;
          if (!match) begin
            state_d     = ACQUIRE;
            match_cnt_d = '0;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
          end
        end else if (cnt_q == TIMEOUT) begin
          state_d     = LOST;
          match_cnt_d = '0;
        end
      end
      LOST: begin
        if (sig_edge) begin
          state_d     = ACQUIRE;
          match_cnt_d = '0;
        end
      end
      default: begin
        state_d     = IDLE;
        match_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      cnt_q       <= '0;
      state_q     <= IDLE;
      match_cnt_q <= '0;
      locked_q    <= 1'b0;
      lost_q      <= 1'b0;
      pv_q        <= 1'b0;
      hp_q        <= '0;
      err_q       <= '0;
    end else begin
      s1_q        <= sig_in;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      locked_q    <= (state_d == LOCKED);
      lost_q      <= (state_d == LOST);
      pv_q        <= pv_d;
      hp_q        <= hp_d;
      err_q       <= err_d;
    end
  end

  assign locked       = locked_q;
  assign lost         = lost_q;
  assign period_valid = pv_q;
  assign half_period  = hp_q;
  assign err_count    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_ratio_monitor.sv
`default_nettype none
// Bench for clock_ratio_monitor: TOLERANCE=0 and TOLERANCE=1 instances share sig_in
// and are compared every cycle against an interval-level model of the monitor.
module tb_clock_ratio_monitor;

  localparam int FACTOR     = 5;
  localparam int TIMEOUT    = 32;
  localparam int LOCK_COUNT = 4;
  localparam int M_IDLE = 0, M_ACQ = 1, M_LOCKED = 2, M_LOST = 3;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       sig_in;
  logic [1:0] locked, lost, pv;
  logic [7:0] hp  [2];
  logic [7:0] err [2];

  int st [2], m [2], errm [2], hpm [2], age [2], tol [2];
  bit pve [2];
  int pend;
  int n_chk = 0, n_pass = 0;

  always #5 clk_in = ~clk_in;

  clock_ratio_monitor #(.FACTOR(8'd5), .TOLERANCE(8'd0), .LOCK_COUNT(4), .TIMEOUT(8'd32)) dut0 (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in),
    .locked(locked[0]), .lost(lost[0]), .period_valid(pv[0]),
    .half_period(hp[0]), .err_count(err[0])
  );

  clock_ratio_monitor #(.FACTOR(8'd5), .TOLERANCE(8'd1), .LOCK_COUNT(4), .TIMEOUT(8'd32)) dut1 (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in),
    .locked(locked[1]), .lost(lost[1]), .period_valid(pv[1]),
    .half_period(hp[1]), .err_count(err[1])
  );

  task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s dut%0d t=%0t: observed %0d, expected %0d", tag, k, $time, obs, exp);
      $error("%s dut%0d observed %0d expected %0d", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      st[k] = M_IDLE; m[k] = 0; errm[k] = 0; hpm[k] = 0; age[k] = 0; pve[k] = 1'b0;
    end
  endtask

  // One clk_in cycle of the model; 'fire' marks the first cycle in which an
  // edge's effect is visible, and age counts cycles since the previous one.
  task automatic model_step(input bit fire);
    int d;
    for (int k = 0; k < 2; k++) begin
      pve[k] = 1'b0;
      age[k]++;
      if (fire) begin
        if (st[k] == M_IDLE || st[k] == M_LOST) begin
          st[k] = M_ACQ;
          m[k]  = 0;
        end else begin
          pve[k] = 1'b1;
          hpm[k] = age[k];
          d = age[k] - FACTOR;
          if (d < 0) d = -d;
          if (st[k] == M_ACQ) begin
            if (d <= tol[k]) begin
              m[k]++;
              if (m[k] == LOCK_COUNT) st[k] = M_LOCKED;
            end else m[k] = 0;
          end else if (d > tol[k]) begin
            st[k] = M_ACQ;
            m[k]  = 0;
            if (errm[k] < 255) errm[k]++;
          end
        end
        age[k] = 0;
      end else if ((st[k] == M_ACQ || st[k] == M_LOCKED) && age[k] == TIMEOUT) begin
        st[k] = M_LOST;
        m[k]  = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk("locked", k, {7'd0, locked[k]}, (st[k] == M_LOCKED) ? 8'd1 : 8'd0);
      chk("lost", k, {7'd0, lost[k]}, (st[k] == M_LOST) ? 8'd1 : 8'd0);
      chk("period_valid", k, {7'd0, pv[k]}, {7'd0, pve[k]});
      chk("half_period", k, hp[k], 8'(hpm[k]));
      chk("err_count", k, err[k], 8'(errm[k]));
    end
  endtask

  task automatic step();
    bit fire;
    @(posedge clk_in);
    #1;
    fire = 1'b0;
    if (pend > 0) begin
      pend--;
      fire = (pend == 0);
    end
    model_step(fire);
    check_all();
  endtask

  // A sig_in change becomes visible on the outputs three clock edges later.
  task automatic run_half(input int len);
    sig_in = ~sig_in;
    pend   = 3;
    repeat (len) step();
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    pend  = sig_in ? 3 : 0;
  endtask

  task automatic async_reset(input logic level);
    #4;
    rst_n  = 1'b0;
    sig_in = level;
    pend   = 0;
    model_reset();
    #1;
    check_all();
    repeat (3) step();
    release_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, len;
    tol[0] = 0;
    tol[1] = 1;
    rst_n  = 1'b0;
    sig_in = 1'b0;
    pend   = 0;
    model_reset();
    repeat (3) step();
    chk("reset_locked", 0, {7'd0, locked[0]}, 8'd0);
    chk("reset_hp", 0, hp[0], 8'd0);
    release_reset();
    repeat (2) step();

    // clean lock: one discarded edge then four matches
    repeat (7) run_half(5);
    chk("clean_lock", 0, {7'd0, locked[0]}, 8'd1);
    chk("clean_err", 0, err[0], 8'd0);

    // one stretched half-period, then relock
    run_half(7);
    repeat (5) run_half(5);
    chk("stretch_relock", 0, {7'd0, locked[0]}, 8'd1);
    chk("stretch_err", 0, err[0], 8'd1);

    // loss and recovery
    repeat (40) step();
    chk("loss", 0, {7'd0, lost[0]}, 8'd1);
    repeat (6) run_half(5);
    chk("loss_relock", 0, {7'd0, locked[0]}, 8'd1);

    // edge coinciding with timeout is measured, not lost
    run_half(32);
    run_half(5);
    chk("timeout_edge_lost", 0, {7'd0, lost[0]}, 8'd0);
    chk("timeout_edge_hp", 0, hp[0], 8'd32);
    chk("timeout_edge_err", 0, err[0], 8'd2);

    // alternating 4/6: only the tolerant instance locks
    repeat (5) begin
      run_half(4);
      run_half(6);
    end
    chk("alt_lock_tol1", 1, {7'd0, locked[1]}, 8'd1);
    chk("alt_lock_tol0", 0, {7'd0, locked[0]}, 8'd0);
    run_half(7);
    run_half(5);
    chk("alt_drop_tol1", 1, {7'd0, locked[1]}, 8'd0);
    chk("alt_err_tol1", 1, err[1], 8'd3);

    // randomized half-periods
    repeat (80) begin
      r = $urandom_range(0, 9);
      if (r < 4)      len = 5;
      else if (r < 6) len = (r == 4) ? 4 : 6;
      else            len = $urandom_range(3, 40);
      run_half(len);
    end

    // reset in ACQUIRE with three matches accumulated
    run_half(9);
    run_half(9);
    repeat (3) run_half(5);
    sig_in = ~sig_in;
    pend   = 3;
    repeat (3) step();
    chk("pre_reset_acq", 0, {7'd0, locked[0]}, 8'd0);
    async_reset(1'b0);
    repeat (4) run_half(5);
    chk("post_reset_not_yet", 0, {7'd0, locked[0]}, 8'd0);
    run_half(5);
    chk("post_reset_lock", 0, {7'd0, locked[0]}, 8'd1);

    // reset with sig_in high: the spurious first edge is discarded
    async_reset(1'b1);
    repeat (5) step();
    repeat (3) run_half(5);
    chk("spurious_not_yet", 0, {7'd0, locked[0]}, 8'd0);
    run_half(5);
    chk("spurious_lock", 0, {7'd0, locked[0]}, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clock_ratio_monitor.md
# clock_ratio_monitor

Measures the half-period of a divided clock, as produced by the team's `ClockDivider`, against the fast clock that generated it, and reports lock and loss. It is the checking end of the divider. The block sits beside the simulated PLL divider in the trigger path. Downstream trigger logic waits on `locked` before arming, and the counters and `lost` flag provide status and debug visibility.

## Interface
Parameters:
- FACTOR, 8'd5: expected half-period of `sig_in`, in `clk_in` cycles.
- TOLERANCE, 8'd0: allowed absolute deviation from FACTOR.
- LOCK_COUNT, 4: consecutive matching half-periods needed for lock. Legal range 1..15.
- TIMEOUT, 8'd32: number of `clk_in` cycles without a `sig_in` edge that declares loss. Must satisfy FACTOR+TOLERANCE < TIMEOUT ≤ 255.

Ports:
- clk_in, input, 1: fast reference clock. Every register is on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- sig_in, input, 1: divided clock under test. Treated as asynchronous to `clk_in`.
- locked, output, 1: high while the FSM is in LOCKED.
- lost, output, 1: high while the FSM is in LOST.
- period_valid, output, 1: one-cycle pulse marking a new `half_period` value.
- half_period, output, 8: last measured half-period. Holds between pulses.
- err_count, output, 8: saturating count of lock drops caused by a mismatch.

## Operation
- Synchronizer: `sig_in` passes through s1 and then s2, and s3 holds the previous s2. The signal `edge` is s2 XOR s3, so both polarities count.
- Interval counter `cnt`, 8 bits:
  - Increments every cycle and saturates at 255.
  - In an edge cycle, `cnt` is set to 1.
  - The value `cnt` holds in the edge cycle is the measured interval.
- Match test: a measurement matches when |cnt − FACTOR| ≤ TOLERANCE. The subtraction uses 9-bit signed arithmetic, so it never wraps.
- `match_cnt` is a 4-bit counter of consecutive matches.
- FSM states: IDLE, ACQUIRE, LOCKED, LOST.
  - IDLE, on edge: go to ACQUIRE and clear `match_cnt`. This measurement is discarded, with no `period_valid`. IDLE has no timeout.
  - ACQUIRE, on edge:
    - Pulse `period_valid` and register `half_period`.
    - On a match, increment `match_cnt`. When the incremented value equals LOCK_COUNT, go to LOCKED.
    - On a mismatch, clear `match_cnt`.
  - LOCKED, on edge:
    - Pulse `period_valid` and register `half_period`.
    - On a match, stay in LOCKED.
    - On a mismatch, go to ACQUIRE, clear `match_cnt`, and increment `err_count` (saturating at 255).
  - ACQUIRE or LOCKED, when `cnt` == TIMEOUT and there is no edge: go to LOST and clear `match_cnt`.
  - LOST, on edge: go to ACQUIRE. This measurement is discarded, with no `period_valid`.
- Edge and timeout in the same cycle: the edge wins, and the measurement (cnt = TIMEOUT) is evaluated normally.
- `locked` and `lost` are registered decodes of the state.

## Timing
- Reset values: s1, s2, s3 = 0; `cnt` = 0; state IDLE; `match_cnt` = 0; `locked` = 0; `lost` = 0; `period_valid` = 0; `half_period` = 0; `err_count` = 0.
- Reset is asynchronous. Asserting it mid-measurement or while locked returns every register to its reset value immediately.
- Input latency: a `sig_in` transition sampled at clock edge k produces `edge` during cycle k+1→k+2. Its effects appear on the outputs after clock edge k+2.
- `period_valid` and the new `half_period` are visible in the cycle after the edge cycle. The same applies to state-driven outputs.
- A spurious edge right after reset, caused by `sig_in` being high while s2/s3 reset to 0, is absorbed by the IDLE discard rule.
- Lock latency with a clean input: 1 discarded edge, then LOCK_COUNT matching edges. `locked` rises one cycle after the LOCK_COUNT-th matching edge cycle.
- Loss latency: `lost` rises one cycle after the cycle in which `cnt` reaches TIMEOUT.
- `sig_in` half-periods below 3 `clk_in` cycles are out of scope. The measured values are then undefined, but the FSM must stay in a legal state.

## Test plan
- Reset, then drive `sig_in` from a ClockDivider with FACTOR=5 (defaults) -> after 1 discarded edge and 4 edges with `half_period`=5, `locked`=1; `err_count`=0.
- While locked, stretch one half-period to 7 cycles -> `period_valid` with `half_period`=7, `locked` falls, `err_count`=1. After 4 further edges at 5 cycles, `locked`=1 again.
- TOLERANCE=1, half-periods alternating 4 and 6 -> lock is reached. A half-period of 7 -> lock drops.
- While locked, hold `sig_in` constant -> `lost`=1 exactly 33 cycles after the last edge cycle. The next edge -> ACQUIRE with no `period_valid`. Then 4 matches -> locked.
- An edge arriving in the same cycle that `cnt`=32 (TIMEOUT) -> no LOST. `half_period`=32 is reported as a mismatch.
- Assert `rst_n` mid-ACQUIRE with `match_cnt`=3 -> every output is 0 immediately. After release, the full 1+4 edge sequence is required to lock.
